// File: rtl/stq_adata_wrsched.sv
// Write scheduler for the store-queue adata table. Each requesting lane is
// buffered in a small FIFO. Up to two FIFO heads with distinct WQ indices are
// issued per cycle, round-robin, onto registered write ports wrt0/wrt1.
module stq_adata_wrsched #(
  parameter int unsigned REQ    = 3,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned WQ_W   = 6,
  parameter int unsigned AD_W   = 5,
  localparam int unsigned PEND_W = $clog2(REQ * DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [REQ-1:0]       req_valid,
  output logic [REQ-1:0]       req_ready,
  input  logic [REQ*WQ_W-1:0]  req_WQ,
  input  logic [REQ*AD_W-1:0]  req_adata,
  output logic                 wrt0_en,
  output logic [WQ_W-1:0]      wrt0_WQ,
  output logic [AD_W-1:0]      wrt0_adata,
  output logic                 wrt1_en,
  output logic [WQ_W-1:0]      wrt1_WQ,
  output logic [AD_W-1:0]      wrt1_adata,
  output logic [PEND_W-1:0]    pend_cnt,
  output logic                 idle
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned LANE_W = $clog2(REQ);

  // Per-lane FIFO state
  logic [PTR_W-1:0] rd_ptr_q [REQ];
  logic [PTR_W-1:0] wr_ptr_q [REQ];
  logic [CNT_W-1:0] cnt_q    [REQ];
  logic [WQ_W-1:0]  mem_wq_q [REQ][DEPTH];
  logic [AD_W-1:0]  mem_ad_q [REQ][DEPTH];

  logic [LANE_W-1:0] rr_ptr_q;
  logic [LANE_W-1:0] rr_ptr_d;

  logic [REQ-1:0]   fifo_empty;
  logic [REQ-1:0]   fifo_full;
  logic [REQ-1:0]   push;
  logic [REQ-1:0]   pop;
  logic [WQ_W-1:0]  head_wq [REQ];
  logic [AD_W-1:0]  head_ad [REQ];

  logic              a_vld;
  logic [LANE_W-1:0] a_lane;
  logic [WQ_W-1:0]   a_wq;
  logic [AD_W-1:0]   a_ad;
  logic              b_vld;
  logic [LANE_W-1:0] b_lane;
  logic [WQ_W-1:0]   b_wq;
  logic [AD_W-1:0]   b_ad;
  logic [LANE_W-1:0] last_lane;

  // Lane k positions after base, modulo REQ.
  function automatic logic [LANE_W-1:0] lane_at(input logic [LANE_W-1:0] base,
                                                 input int unsigned k);
    int unsigned s;
    s = int'(base) + k;
    if (s >= REQ) s = s - REQ;
    return LANE_W'(s);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // FIFO status, heads and handshake; full FIFOs stay not-ready even when popping.
  always_comb begin
    for (int i = 0; i < REQ; i++) begin
      fifo_empty[i] = (cnt_q[i] == '0);
      fifo_full[i]  = (cnt_q[i] == CNT_W'(DEPTH));
      head_wq[i]    = mem_wq_q[i][rd_ptr_q[i]];
      head_ad[i]    = mem_ad_q[i][rd_ptr_q[i]];
    end
    req_ready = ~fifo_full & {REQ{~flush}};
    push      = req_valid & req_ready;
  end

  // Round-robin pick of up to two heads; heads matching pick A's index wait a cycle.
  always_comb begin
    a_vld  = 1'b0;
    a_lane = '0;
    a_wq   = '0;
    a_ad   = '0;
    b_vld  = 1'b0;
    b_lane = '0;
    b_wq   = '0;
    b_ad   = '0;
    for (int k = 0; k < REQ; k++) begin
      if (!fifo_empty[lane_at(rr_ptr_q, k)]) begin
        if (!a_vld) begin
          a_vld  = 1'b1;
          a_lane = lane_at(rr_ptr_q, k);
          a_wq   = head_wq[lane_at(rr_ptr_q, k)];
          a_ad   = head_ad[lane_at(rr_ptr_q, k)];
        end else if (!b_vld && (head_wq[lane_at(rr_ptr_q, k)] != a_wq)) begin
          b_vld  = 1'b1;
          b_lane = lane_at(rr_ptr_q, k);
          b_wq   = head_wq[lane_at(rr_ptr_q, k)];
          b_ad   = head_ad[lane_at(rr_ptr_q, k)];
        end
      end
    end
    for (int i = 0; i < REQ; i++) begin
      pop[i] = (a_vld && (a_lane == LANE_W'(i))) || (b_vld && (b_lane == LANE_W'(i)));
    end
    last_lane = b_vld ? b_lane : a_lane;
    rr_ptr_d  = (last_lane == LANE_W'(REQ - 1)) ? '0 : last_lane + 1'b1;
  end

  // Occupancy summed across lanes.
  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < REQ; i++) begin
      pend_cnt = pend_cnt + PEND_W'(cnt_q[i]);
    end
    idle = (pend_cnt == '0) && !wrt0_en && !wrt1_en;
  end

  // FIFO storage; push is already gated off during flush.
  always_ff @(posedge clk) begin
    for (int i = 0; i < REQ; i++) begin
      if (push[i]) begin
        mem_wq_q[i][wr_ptr_q[i]] <= req_WQ[i*WQ_W +: WQ_W];
        mem_ad_q[i][wr_ptr_q[i]] <= req_adata[i*AD_W +: AD_W];
      end
    end
  end

  // FIFO pointers, round-robin pointer and registered write ports.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REQ; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      rr_ptr_q   <= '0;
      wrt0_en    <= 1'b0;
      wrt0_WQ    <= '0;
      wrt0_adata <= '0;
      wrt1_en    <= 1'b0;
      wrt1_WQ    <= '0;
      wrt1_adata <= '0;
    end else if (flush) begin
      // rr_ptr and port data are deliberately left as they are
      for (int i = 0; i < REQ; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      wrt0_en <= 1'b0;
      wrt1_en <= 1'b0;
    end else begin
      for (int i = 0; i < REQ; i++) begin
        if (push[i]) wr_ptr_q[i] <= ptr_inc(wr_ptr_q[i]);
        if (pop[i])  rd_ptr_q[i] <= ptr_inc(rd_ptr_q[i]);
        if (push[i] && !pop[i]) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end else if (!push[i] && pop[i]) begin
          cnt_q[i] <= cnt_q[i] - CNT_W'(1);
        end
      end
      wrt0_en <= a_vld;
      if (a_vld) begin
        wrt0_WQ    <= a_wq;
        wrt0_adata <= a_ad;
        rr_ptr_q   <= rr_ptr_d;
      end
      wrt1_en <= b_vld;
      if (b_vld) begin
        wrt1_WQ    <= b_wq;
        wrt1_adata <= b_ad;
      end
    end
  end

endmodule
